// File: rtl/cpu_pkg.sv
// Shared definitions for the memory responder: IO port address, status bit
// layout and boot FSM encoding.
package cpu_pkg;

   localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFF_FFF0;

   // Bit positions inside the IO status word
   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } boot_state_t;

   // Pack FIFO flags into the word returned by a read of the IO address
   function automatic logic [31:0] status_word(input logic ovf,
                                               input logic full,
                                               input logic empty);
      logic [31:0] s;
      s             = '0;
      s[STAT_OVF]   = ovf;
      s[STAT_FULL]  = full;
      s[STAT_EMPTY] = empty;
      return s;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Output-port FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and the sticky
// overflow flag is raised.
module io_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic         overflow,
   output logic [W-1:0] head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers, occupancy and sticky overflow; pointers wrap naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // Entry storage needs no reset; occupancy tracks validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM model for a CPU: boots by streaming a program image
// into RAM while holding the CPU in reset, then serves CPU reads/writes and
// exposes an output FIFO at a memory-mapped IO address.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int          DEPTH      = 256,
   parameter logic [31:0] IO_ADDR    = IO_ADDR_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] datao,
   input  logic        rw,
   output logic [31:0] data,
   output logic        cpu_reset,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        io_valid,
   input  logic        io_ready,
   output logic [31:0] io_data
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   ram [DEPTH];
   boot_state_t   state, state_nxt;
   logic [AW-1:0] load_ptr, load_ptr_nxt;
   logic          load_fire;
   logic          in_ram, is_io;
   logic [AW-1:0] ram_idx;
   logic          cpu_ram_wr, io_push, io_pop;
   logic          fifo_full, fifo_empty, fifo_ovf;

   assign in_ram     = (address < 32'(DEPTH));
   assign is_io      = (address == IO_ADDR);
   assign ram_idx    = address[AW-1:0];
   assign load_fire  = (state == ST_LOAD) && load_valid;
   assign cpu_ram_wr = (state == ST_RUN) && !rw && in_ram;
   assign io_push    = (state == ST_RUN) && !rw && is_io;
   assign io_pop     = io_valid && io_ready;

   // Boot FSM state and load pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_LOAD;
         load_ptr <= '0;
      end else begin
         state    <= state_nxt;
         load_ptr <= load_ptr_nxt;
      end
   end

   // Boot FSM next state and outputs; pointer holds at the last word
   always_comb begin
      state_nxt    = state;
      load_ptr_nxt = load_ptr;
      cpu_reset    = 1'b0;
      load_ready   = 1'b0;
      case (state)
         ST_LOAD: begin
            cpu_reset  = 1'b1;
            load_ready = 1'b1;
            if (load_fire) begin
               if (load_last || load_ptr == AW'(DEPTH - 1))
                  state_nxt = ST_RUN;
               else
                  load_ptr_nxt = load_ptr + 1'b1;
            end
         end
         ST_RUN: state_nxt = ST_RUN;
         default: state_nxt = ST_LOAD;
      endcase
   end

   // RAM write port: image load in LOAD, CPU stores in RUN; never cleared
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (load_fire)       ram[load_ptr] <= load_data;
         else if (cpu_ram_wr) ram[ram_idx]  <= datao;
      end
   end

   // Combinational read mux: RAM, IO status, or zero
   always_comb begin
      data = '0;
      if (rw) begin
         if (in_ram)     data = ram[ram_idx];
         else if (is_io) data = status_word(fifo_ovf, fifo_full, fifo_empty);
      end
   end

   io_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (io_push),
      .din      (datao),
      .pop      (io_pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (fifo_ovf),
      .head     (io_data)
   );

   // io_valid comes from registered occupancy only, never from io_ready
   assign io_valid = !fifo_empty;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

   localparam int          DEPTH = 256;
   localparam logic [31:0] IO    = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address, datao, data, load_data, io_data;
   logic        rw, cpu_reset, load_valid, load_ready, load_last, io_valid, io_ready;

   int checks = 0;
   int passes = 0;

   mem_responder #(.DEPTH(DEPTH), .IO_ADDR(IO), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .datao      (datao),
      .rw         (rw),
      .data       (data),
      .cpu_reset  (cpu_reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .io_valid   (io_valid),
      .io_ready   (io_ready),
      .io_data    (io_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] v, input logic last);
      load_valid = 1'b1;
      load_data  = v;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      rw      = 1'b0;
      address = a;
      datao   = d;
      step();
      rw      = 1'b1;
      address = '0;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] v);
      rw      = 1'b1;
      address = a;
      #1;
      v = data;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset got %b want 1", cpu_reset); else passes++;
      checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got %b want 1", load_ready); else passes++;
      checks++; if (io_valid !== 1'b0) $display("FAIL reset_io_valid got %b want 0", io_valid); else passes++;
   endtask

   // DEPTH words without load_last; boot ends after the last word
   task automatic test_stream_full();
      logic [31:0] v;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         load_word(32'(1000 + i), 1'b0);
         if (i == DEPTH - 2) begin
            checks++; if (cpu_reset !== 1'b1) $display("FAIL stream_still_loading got %b want 1", cpu_reset); else passes++;
         end
      end
      checks++; if (cpu_reset !== 1'b0) $display("FAIL stream_run got %b want 0", cpu_reset); else passes++;
      // extra transfer after RUN must not wrap onto word 0
      load_word(32'h0000_0BAD, 1'b0);
      cpu_read(32'd0, v);
      checks++; if (v !== 32'd1000) $display("FAIL stream_word0 got %0d want 1000", v); else passes++;
      cpu_read(32'(DEPTH - 1), v);
      checks++; if (v !== 32'd1255) $display("FAIL stream_last got %0d want 1255", v); else passes++;
   endtask

   task automatic test_load3();
      logic [31:0] v;
      apply_reset();
      cpu_write(32'd10, 32'hDEAD);   // ignored while loading
      load_word(32'd11, 1'b0);
      load_word(32'd22, 1'b0);
      checks++; if (cpu_reset !== 1'b1) $display("FAIL load3_pre got %b want 1", cpu_reset); else passes++;
      load_word(32'd33, 1'b1);
      checks++; if ({cpu_reset, load_ready} !== 2'b00) $display("FAIL load3_run got %b want 00", {cpu_reset, load_ready}); else passes++;
      cpu_read(32'd0, v);
      checks++; if (v !== 32'd11) $display("FAIL load3_r0 got %0d want 11", v); else passes++;
      cpu_read(32'd1, v);
      checks++; if (v !== 32'd22) $display("FAIL load3_r1 got %0d want 22", v); else passes++;
      cpu_read(32'd2, v);
      checks++; if (v !== 32'd33) $display("FAIL load3_r2 got %0d want 33", v); else passes++;
      cpu_read(32'd10, v);
      checks++; if (v !== 32'd1010) $display("FAIL load3_ignore_cpu_wr got %0d want 1010", v); else passes++;
   endtask

   task automatic test_rw();
      logic [31:0] v;
      cpu_write(32'd5, 32'h0000_ABCD);
      cpu_read(32'd5, v);
      checks++; if (v !== 32'h0000_ABCD) $display("FAIL rw_addr5 got %h want 0000abcd", v); else passes++;
      cpu_write(32'(DEPTH + 3), 32'h1234);
      cpu_read(32'(DEPTH + 3), v);
      checks++; if (v !== 32'd0) $display("FAIL rw_oob got %h want 0", v); else passes++;
      cpu_read(32'd3, v);
      checks++; if (v !== 32'd1003) $display("FAIL rw_no_alias got %0d want 1003", v); else passes++;
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] v;
      io_ready = 1'b0;
      for (int i = 1; i <= 5; i++) cpu_write(IO, 32'(i));
      cpu_read(IO, v);
      checks++; if (v !== 32'b110) $display("FAIL ovf_status got %b want 110", v); else passes++;
      io_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (io_valid !== 1'b1 || io_data !== 32'(i))
            $display("FAIL ovf_drain%0d got valid=%b data=%0d want valid=1 data=%0d", i, io_valid, io_data, i);
         else passes++;
         step();
      end
      io_ready = 1'b0;
      cpu_read(IO, v);
      checks++; if (v !== 32'b101) $display("FAIL ovf_status_after got %b want 101", v); else passes++;
   endtask

   task automatic test_push_pop_full();
      logic [31:0] v;
      apply_reset();
      load_word(32'd7, 1'b1);
      io_ready = 1'b0;
      for (int i = 5; i <= 8; i++) cpu_write(IO, 32'(i));
      io_ready = 1'b1;
      cpu_write(IO, 32'd9);          // push while full with a pop
      io_ready = 1'b0;
      cpu_read(IO, v);
      checks++; if (v !== 32'b010) $display("FAIL pp_status got %b want 010", v); else passes++;
      io_ready = 1'b1;
      for (int i = 6; i <= 9; i++) begin
         checks++;
         if (io_valid !== 1'b1 || io_data !== 32'(i))
            $display("FAIL pp_drain%0d got valid=%b data=%0d want valid=1 data=%0d", i, io_valid, io_data, i);
         else passes++;
         step();
      end
      io_ready = 1'b0;
      checks++; if (io_valid !== 1'b0) $display("FAIL pp_empty got %b want 0", io_valid); else passes++;
   endtask

   task automatic test_midload_reset();
      logic [31:0] v;
      io_ready = 1'b0;
      cpu_write(IO, 32'd42);         // leave something in the FIFO
      apply_reset();
      load_word(32'h77, 1'b0);
      load_word(32'h88, 1'b0);
      apply_reset();
      checks++; if (io_valid !== 1'b0) $display("FAIL mid_fifo_empty got %b want 0", io_valid); else passes++;
      checks++; if (cpu_reset !== 1'b1) $display("FAIL mid_cpu_reset got %b want 1", cpu_reset); else passes++;
      load_word(32'h55, 1'b1);
      cpu_read(32'd0, v);
      checks++; if (v !== 32'h55) $display("FAIL mid_word0 got %h want 55", v); else passes++;
      cpu_read(32'd1, v);
      checks++; if (v !== 32'h88) $display("FAIL mid_word1_kept got %h want 88", v); else passes++;
   endtask

   initial begin
      reset      = 1'b1;
      address    = '0;
      datao      = '0;
      rw         = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      io_ready   = 1'b0;
      #1;
      test_reset();
      test_stream_full();
      test_load3();
      test_rw();
      test_fifo_overflow();
      test_push_pop_full();
      test_midload_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 256, RAM size in 32-bit words; power of two; word-addressed.
REQ-002 Parameter IO_ADDR, 32'hFFFF_FFF0, output-port data/status address.
REQ-003 Parameter FIFO_DEPTH, 4, output FIFO entries; power of two.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  32  CPU word address.
REQ-007 datao  in  32  CPU write data.
REQ-008 rw  in  1  1 = read, 0 = write.
REQ-009 data  out  32  read data to CPU.
REQ-010 cpu_reset  out  1  holds the CPU in reset while the program image loads.
REQ-011 load_valid / load_ready / load_data[31:0] / load_last  in/out/in/in  1/1/32/1  image-load handshake.
REQ-012 io_valid / io_ready / io_data[31:0]  out/in/out  1/1/32  output-FIFO drain handshake.

Function
REQ-013 Boot FSM SHALL have two states, LOAD and RUN; reset enters LOAD.
REQ-014 In LOAD: cpu_reset=1, load_ready=1; each cycle with load_valid=1 writes load_data to RAM[load_ptr] and increments load_ptr.
REQ-015 In LOAD, a transfer with load_last=1, or a transfer at load_ptr=DEPTH-1, SHALL move the FSM to RUN on the next edge; load_ptr SHALL NOT wrap.
REQ-016 In RUN: cpu_reset=0, load_ready=0; the FSM stays in RUN until reset.
REQ-017 RAM reads SHALL be combinational: data = RAM[address[log2(DEPTH)-1:0]] in the same cycle, when rw=1 and address<DEPTH.
REQ-018 A read at IO_ADDR SHALL return {29'b0, overflow, full, empty}; a read at any other address >= DEPTH SHALL return 0.
REQ-019 In RUN, rw=0 with address<DEPTH SHALL write datao to RAM at the clock edge; writes to other non-IO addresses SHALL be ignored.
REQ-020 CPU writes in LOAD SHALL be ignored.
REQ-021 In RUN, rw=0 at IO_ADDR SHALL push datao into the FIFO once per cycle the write is presented.
REQ-022 io_valid SHALL equal !empty, and io_data SHALL equal the FIFO head; io_valid&io_ready pops one entry.
REQ-023 A push while full SHALL be dropped and SHALL set sticky overflow, except when a pop occurs in the same cycle, in which case the push is accepted.
REQ-024 A simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-025 The FIFO count SHALL range 0..FIFO_DEPTH; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 No combinational path SHALL exist from io_ready to io_valid.

Reset
REQ-027 Reset SHALL set: FSM=LOAD, load_ptr=0, FIFO pointers and count=0, overflow=0.
REQ-028 After reset: cpu_reset=1, load_ready=1, io_valid=0.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 Reset mid-load SHALL restart loading at word 0.

Structure
REQ-031 IO_ADDR, the status bit positions and the FSM state encoding SHALL live in the shared package cpu_pkg.
REQ-032 The output FIFO SHALL be the sub-module io_fifo (push, pop, full, empty, head); RAM and the boot FSM SHALL stay in mem_responder.

Verification
REQ-033 Load 3 words 11,22,33 with load_last on the third -> RUN next edge, cpu_reset falls; reads at addresses 0..2 return 11,22,33.
REQ-034 Stream DEPTH words with load_last never asserted -> RUN after word DEPTH-1; RAM[0] is not overwritten.
REQ-035 In RUN, write 0xABCD to address 5, then read address 5 -> 0xABCD; read address DEPTH+3 -> 0.
REQ-036 io_ready=0, 5 writes to IO_ADDR (values 1..5) -> status reads 0b110 (overflow, full); drain returns 1,2,3,4, then status reads 0b101.
REQ-037 FIFO full, push of 9 in the same cycle as a pop -> count stays 4, overflow stays 0, 9 is the last value drained.
REQ-038 Assert reset after 2 load transfers -> load_ptr=0, FIFO empty, cpu_reset=1; the next load writes word 0.
